// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, 2-flop input synchronizer, mid-bit sampling.
// Reports good bytes with data_valid and a low stop bit with framing_error.
module uart_rx #(
   parameter int CLK_CYCLES_PER_BIT = 219
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_data,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       active,
   output logic       framing_error
);

   localparam int CW   = $clog2(CLK_CYCLES_PER_BIT);
   localparam int HALF = (CLK_CYCLES_PER_BIT - 1) / 2;
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_CYCLES_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      DONE,
      BREAK
   } state_t;

   logic          r_rxMeta;
   logic          r_rxSync;
   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bitIdx;
   logic [7:0]    r_shift;
   logic [7:0]    r_data;
   logic          r_dataValid;
   logic          r_active;
   logic          r_framingError;

   logic          w_rxS;
   state_t        w_stateNext;
   logic [CW-1:0] w_cntNext;
   logic [2:0]    w_bitIdxNext;
   logic [7:0]    w_shiftNext;
   logic [7:0]    w_dataNext;
   logic          w_dataValidNext;
   logic          w_framingErrorNext;
   logic          w_activeNext;

   assign w_rxS = r_rxSync;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rxMeta <= 1'b1;
         r_rxSync <= 1'b1;
      end else begin
         r_rxMeta <= rx_data;
         r_rxSync <= r_rxMeta;
      end
   end

   // The counter restarts on every state change and on every data sample,
   // so its largest value is CLK_CYCLES_PER_BIT-1 and it never wraps.
   always_comb begin
      w_stateNext        = r_state;
      w_cntNext          = r_cnt + CW'(1);
      w_bitIdxNext       = r_bitIdx;
      w_shiftNext        = r_shift;
      w_dataNext         = r_data;
      w_dataValidNext    = 1'b0;
      w_framingErrorNext = 1'b0;

      case (r_state)
         IDLE: begin
            w_cntNext    = '0;
            w_bitIdxNext = 3'd0;
            if (!w_rxS) begin
               w_stateNext = START;
            end
         end
         START: begin
            if (r_cnt == HALF_LAST) begin
               w_cntNext   = '0;
               w_stateNext = w_rxS ? IDLE : DATA;
            end
         end
         DATA: begin
            if (r_cnt == BIT_LAST) begin
               w_cntNext    = '0;
               w_shiftNext  = {w_rxS, r_shift[7:1]};
               w_bitIdxNext = r_bitIdx + 3'd1;
               if (r_bitIdx == 3'd7) begin
                  w_stateNext = STOP;
               end
            end
         end
         STOP: begin
            if (r_cnt == BIT_LAST) begin
               w_cntNext = '0;
               if (w_rxS) begin
                  w_stateNext     = DONE;
                  w_dataNext      = r_shift;
                  w_dataValidNext = 1'b1;
               end else begin
                  w_stateNext        = BREAK;
                  w_framingErrorNext = 1'b1;
               end
            end
         end
         DONE: begin
            w_cntNext   = '0;
            w_stateNext = IDLE;
         end
         BREAK: begin
            w_cntNext = '0;
            if (w_rxS) begin
               w_stateNext = IDLE;
            end
         end
         default: begin
            w_cntNext   = '0;
            w_stateNext = IDLE;
         end
      endcase

      w_activeNext = (w_stateNext == START) || (w_stateNext == DATA) ||
                     (w_stateNext == STOP);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= IDLE;
         r_cnt          <= '0;
         r_bitIdx       <= 3'd0;
         r_shift        <= 8'h00;
         r_data         <= 8'h00;
         r_dataValid    <= 1'b0;
         r_active       <= 1'b0;
         r_framingError <= 1'b0;
      end else begin
         r_state        <= w_stateNext;
         r_cnt          <= w_cntNext;
         r_bitIdx       <= w_bitIdxNext;
         r_shift        <= w_shiftNext;
         r_data         <= w_dataNext;
         r_dataValid    <= w_dataValidNext;
         r_active       <= w_activeNext;
         r_framingError <= w_framingErrorNext;
      end
   end

   assign data          = r_data;
   assign data_valid    = r_dataValid;
   assign active        = r_active;
   assign framing_error = r_framingError;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives serial frames and compares every active edge and
// output pulse, with its cycle, against events predicted from the frame timing.
module tb_uart_rx;

   localparam int N = 219;
   localparam int H = (N - 1) / 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_data;
   logic [7:0] data;
   logic       data_valid;
   logic       active;
   logic       framing_error;

   uart_rx #(.CLK_CYCLES_PER_BIT(N)) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_data       (rx_data),
      .data          (data),
      .data_valid    (data_valid),
      .active        (active),
      .framing_error (framing_error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum int {EV_RISE, EV_FALL, EV_VALID, EV_FERR} evKind_t;
   typedef struct {
      evKind_t    kind;
      logic [7:0] value;
      int         at;
   } event_t;

   typedef struct {
      logic [7:0] txByte;
      logic       stopBit;
      int         holdLowBits;
      int         gapAfter;
      logic       expValid;
      logic       expFerr;
      logic [7:0] expData;
   } vector_t;

   event_t     expQ[$];
   event_t     obsQ[$];
   int         testsRun = 0;
   int         testsFailed = 0;
   bit         monEnable = 1'b0;
   logic       prevActive;
   logic [7:0] prevData;
   logic [7:0] modelData = 8'h00;
   int         overlapCount = 0;
   int         dataGlitchCount = 0;

   // Observed events are time-stamped one time unit after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (monEnable) begin
            if (active && !prevActive) obsQ.push_back('{EV_RISE, 8'h00, cyc});
            if (!active && prevActive) obsQ.push_back('{EV_FALL, 8'h00, cyc});
            if (data_valid) obsQ.push_back('{EV_VALID, data, cyc});
            if (framing_error) obsQ.push_back('{EV_FERR, data, cyc});
            if (data_valid && framing_error) overlapCount++;
            if (!reset && !data_valid && data !== prevData) dataGlitchCount++;
            prevActive = active;
            prevData   = data;
         end
      end
   end

   task automatic checkSignal(input string name, input int got, input int exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   task automatic checkOutput(input string name);
      int n;
      n = (expQ.size() > obsQ.size()) ? expQ.size() : obsQ.size();
      for (int i = 0; i < n; i++) begin
         testsRun++;
         if (i >= expQ.size()) begin
            testsFailed++;
            $display("[TB] FAIL %s ev%0d: got extra %s data=%h cycle=%0d, expected none",
                     name, i, obsQ[i].kind.name(), obsQ[i].value, obsQ[i].at);
         end else if (i >= obsQ.size()) begin
            testsFailed++;
            $display("[TB] FAIL %s ev%0d: got none, expected %s data=%h cycle=%0d",
                     name, i, expQ[i].kind.name(), expQ[i].value, expQ[i].at);
         end else if (obsQ[i].kind != expQ[i].kind || obsQ[i].value !== expQ[i].value ||
                      obsQ[i].at != expQ[i].at) begin
            testsFailed++;
            $display("[TB] FAIL %s ev%0d: got %s data=%h cycle=%0d, expected %s data=%h cycle=%0d",
                     name, i, obsQ[i].kind.name(), obsQ[i].value, obsQ[i].at,
                     expQ[i].kind.name(), expQ[i].value, expQ[i].at);
         end
      end
      expQ.delete();
      obsQ.delete();
   endtask

   task automatic idle(input int n);
      rx_data = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic sendFrame(input logic [7:0] b, input logic stopBit, input int holdLowBits);
      rx_data = 1'b0;
      repeat (N) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_data = b[i];
         repeat (N) @(negedge clk);
      end
      rx_data = stopBit;
      repeat (stopBit ? N : N * (1 + holdLowBits)) @(negedge clk);
      rx_data = 1'b1;
   endtask

   // The line change made now reaches rx_s two edges later (t0); the stop bit
   // is sampled at t0+H+9N and its result shows one cycle after that.
   task automatic applyStimulus(input vector_t v);
      int t0;
      int tEnd;
      t0   = cyc + 2;
      tEnd = t0 + H + 9 * N + 1;
      expQ.push_back('{EV_RISE, 8'h00, t0 + 1});
      expQ.push_back('{EV_FALL, 8'h00, tEnd});
      if (v.expValid) expQ.push_back('{EV_VALID, v.expData, tEnd});
      if (v.expFerr)  expQ.push_back('{EV_FERR, v.expData, tEnd});
      if (v.expValid) modelData = v.expData;
      sendFrame(v.txByte, v.stopBit, v.holdLowBits);
      idle(v.gapAfter);
   endtask

   vector_t vecs[10];

   initial begin
      int t0;
      int rc;
      vector_t rv;

      vecs[0] = '{8'hA5, 1'b1, 0, N, 1'b1, 1'b0, 8'hA5};
      vecs[1] = '{8'h3C, 1'b0, 2, N, 1'b0, 1'b1, 8'hA5};
      vecs[2] = '{8'h00, 1'b1, 0, 0, 1'b1, 1'b0, 8'h00};
      vecs[3] = '{8'hFF, 1'b1, 0, N, 1'b1, 1'b0, 8'hFF};
      vecs[4] = '{8'h00, 1'b1, 0, 3, 1'b1, 1'b0, 8'h00};
      vecs[5] = '{8'hFF, 1'b1, 0, 3, 1'b1, 1'b0, 8'hFF};
      vecs[6] = '{8'hA5, 1'b1, 0, 3, 1'b1, 1'b0, 8'hA5};
      vecs[7] = '{8'h5A, 1'b1, 0, 3, 1'b1, 1'b0, 8'h5A};
      vecs[8] = '{8'h01, 1'b1, 0, 3, 1'b1, 1'b0, 8'h01};
      vecs[9] = '{8'h80, 1'b1, 0, N, 1'b1, 1'b0, 8'h80};

      rx_data = 1'b1;
      reset   = 1'b1;
      repeat (3) @(negedge clk);
      checkSignal("resetData", int'(data), 0);
      checkSignal("resetValid", int'(data_valid), 0);
      checkSignal("resetActive", int'(active), 0);
      checkSignal("resetFerr", int'(framing_error), 0);
      reset      = 1'b0;
      prevActive = active;
      prevData   = data;
      monEnable  = 1'b1;
      idle(20);

      // Short low glitch: start check at t0+H finds the line high again.
      t0 = cyc + 2;
      expQ.push_back('{EV_RISE, 8'h00, t0 + 1});
      expQ.push_back('{EV_FALL, 8'h00, t0 + H + 1});
      rx_data = 1'b0;
      repeat (50) @(negedge clk);
      idle(2 * N);
      checkOutput("glitch");
      checkSignal("glitchData", int'(data), 0);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d", i));
         checkSignal($sformatf("vec%0dData", i), int'(data), int'(vecs[i].expData));
      end

      // Reset pulse in the middle of data bit 4 aborts the frame silently.
      t0 = cyc + 2;
      expQ.push_back('{EV_RISE, 8'h00, t0 + 1});
      rx_data = 1'b0;
      repeat (N) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx_data = ((8'hC3 >> i) & 8'h01) != 8'h00;
         repeat (N) @(negedge clk);
      end
      rx_data = 1'b0;
      repeat (N / 2) @(negedge clk);
      reset   = 1'b1;
      rx_data = 1'b1;
      rc      = cyc;
      expQ.push_back('{EV_FALL, 8'h00, rc + 1});
      @(negedge clk);
      checkSignal("midResetData", int'(data), 0);
      checkSignal("midResetValid", int'(data_valid), 0);
      checkSignal("midResetActive", int'(active), 0);
      checkSignal("midResetFerr", int'(framing_error), 0);
      reset     = 1'b0;
      modelData = 8'h00;
      idle(2 * N);
      checkOutput("resetAbort");
      applyStimulus('{8'h5A, 1'b1, 0, N, 1'b1, 1'b0, 8'h5A});
      checkOutput("afterReset");
      checkSignal("afterResetData", int'(data), 'h5A);

      for (int i = 0; i < 8; i++) begin
         rv.txByte      = 8'($urandom);
         rv.stopBit     = ($urandom_range(0, 4) != 0);
         rv.holdLowBits = 0;
         rv.gapAfter    = rv.stopBit ? $urandom_range(0, 300) : N + $urandom_range(0, 300);
         rv.expValid    = rv.stopBit;
         rv.expFerr     = !rv.stopBit;
         rv.expData     = rv.stopBit ? rv.txByte : modelData;
         applyStimulus(rv);
         checkOutput($sformatf("rand%0d", i));
         checkSignal($sformatf("rand%0dData", i), int'(data), int'(modelData));
      end

      checkSignal("noPulseOverlap", overlapCount, 0);
      checkSignal("dataOnlyOnValid", dataGlitchCount, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
